// File: rtl/mips_pkg.sv
// Shared MDU types: op codes, sequencer states and the divide-by-zero LO value.
package mips_pkg;

  typedef enum logic [2:0] {
    MULT  = 3'b000,
    MULTU = 3'b001,
    DIV   = 3'b010,
    DIVU  = 3'b011,
    MUL   = 3'b100,
    MTHI  = 3'b101,
    MTLO  = 3'b110,
    NOP   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MRUN = 2'd1,
    DRUN = 2'd2,
    FIX  = 2'd3
  } mdu_state_e;

  localparam logic [31:0] MDU_DIV0_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/mdu_iter_step.sv
// One combinational MDU iteration: shift-add accumulate (multiply) or one
// restoring shift-subtract step (divide) on the {hi, lo} working pair.
module mdu_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic               div_i,
  input  logic [WIDTH-1:0]   hi_i,
  input  logic [WIDTH-1:0]   lo_i,
  input  logic [2*WIDTH-1:0] mcand_i,
  input  logic               mbit_i,
  output logic [WIDTH-1:0]   hi_o,
  output logic [WIDTH-1:0]   lo_o
);

  logic [2*WIDTH-1:0] sum;
  logic [WIDTH:0]     diff;

  always_comb begin
    sum  = {hi_i, lo_i} + (mbit_i ? mcand_i : '0);
    // divisor sits in the low half of mcand_i during a divide
    diff = {hi_i, lo_i[WIDTH-1]} - {1'b0, mcand_i[WIDTH-1:0]};
    if (!div_i) begin
      {hi_o, lo_o} = sum;
    end else if (!diff[WIDTH]) begin
      hi_o = diff[WIDTH-1:0];
      lo_o = {lo_i[WIDTH-2:0], 1'b1};
    end else begin
      hi_o = {hi_i[WIDTH-2:0], lo_i[WIDTH-1]};
      lo_o = {lo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Iterative multiply/divide unit with HI/LO and a stall interface to the hazard unit.
// Optional MDU_EARLY_OUT_EN: multiply ends once the remaining multiplier bits are zero.
module mdu_sequencer
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             flush,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             rd_req,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdu_state_e         state_q, state_d;
  mdu_op_e            op_e;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   w_hi_q, w_hi_d, w_lo_q, w_lo_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic               done_q, done_d;
  logic               is_div_q, is_div_d, neg_p_q, neg_p_d, neg_r_q, neg_r_d, div0_q, div0_d;
  logic               accept, iter_op, signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]   abs_a, abs_b, step_hi, step_lo, quo, rem;
  logic [2*WIDTH-1:0] prod;

  assign op_e = mdu_op_e'(op);

  mdu_iter_step #(.WIDTH(WIDTH)) u_step (
    .div_i   (state_q == DRUN),
    .hi_i    (w_hi_q),
    .lo_i    (w_lo_q),
    .mcand_i (mcand_q),
    .mbit_i  (mplier_q[0]),
    .hi_o    (step_hi),
    .lo_o    (step_lo)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    w_hi_d   = w_hi_q;
    w_lo_d   = w_lo_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    is_div_d = is_div_q;
    neg_p_d  = neg_p_q;
    neg_r_d  = neg_r_q;
    div0_d   = div0_q;
    accept    = start && !flush && (state_q == IDLE) && (op_e != NOP);
    iter_op   = op_e inside {MULT, MULTU, DIV, DIVU, MUL};
    signed_op = op_e inside {MULT, DIV, MUL};
    a_neg     = signed_op & rs_val[WIDTH-1];
    b_neg     = signed_op & rt_val[WIDTH-1];
    abs_a     = a_neg ? -rs_val : rs_val;
    abs_b     = b_neg ? -rt_val : rt_val;
    prod      = {w_hi_q, w_lo_q};
    quo       = w_lo_q;
    rem       = w_hi_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (op_e == MTHI) begin
            hi_d   = rs_val;
            done_d = 1'b1;
          end else if (op_e == MTLO) begin
            lo_d   = rs_val;
            done_d = 1'b1;
          end else begin
            cnt_d    = CNT_W'(WIDTH);
            w_hi_d   = '0;
            is_div_d = op_e inside {DIV, DIVU};
            neg_p_d  = a_neg ^ b_neg;
            neg_r_d  = a_neg;
            div0_d   = (rt_val == '0);
            if (op_e inside {DIV, DIVU}) begin
              w_lo_d  = abs_a;
              mcand_d = {{WIDTH{1'b0}}, abs_b};
              state_d = DRUN;
            end else begin
              w_lo_d   = '0;
              mcand_d  = {{WIDTH{1'b0}}, abs_a};
              mplier_d = abs_b;
              state_d  = MRUN;
            end
          end
        end
      end
      MRUN: begin
        w_hi_d   = step_hi;
        w_lo_d   = step_lo;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = FIX;
`ifdef MDU_EARLY_OUT_EN
        else if (mplier_q[WIDTH-1:1] == '0) state_d = FIX;
`endif
      end
      DRUN: begin
        w_hi_d = step_hi;
        w_lo_d = step_lo;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = FIX;
      end
      FIX: begin
        // divide-by-zero quotient is forced; the remainder already equals |dividend|
        if (is_div_q) begin
          lo_d = div0_q ? WIDTH'(MDU_DIV0_LO) : (neg_p_q ? -quo : quo);
          hi_d = neg_r_q ? -rem : rem;
        end else begin
          if (neg_p_q) prod = -prod;
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      w_hi_q   <= '0;
      w_lo_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      is_div_q <= 1'b0;
      neg_p_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      w_hi_q   <= w_hi_d;
      w_lo_q   <= w_lo_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      is_div_q <= is_div_d;
      neg_p_q  <= neg_p_d;
      neg_r_q  <= neg_r_d;
      div0_q   <= div0_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign stall = (busy & (rd_req | start)) | (accept & iter_op & rd_req);
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule
